alu_cmd_sequencer: RTL and testbench

- Upstream feeder and result capture stage for the team's 8-bit combinational ALU (operands A, B, 3-bit Op, result R).
- Buffers operand/opcode commands in a small FIFO and issues one command per cycle to the ALU.
- Registers the ALU result with a valid/ready output handshake, which gives the downstream stage a clean pipelined interface.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_cmd_fifo.sv | 74 +++++++
 rtl/alu_cmd_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared widths and the queued command record for the ALU
//               command sequencer. The record gains a chain flag when
//               ALU_CHAIN_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_OPW = 3;

  typedef struct packed {
    logic [DEF_DW-1:0]  a;
    logic [DEF_DW-1:0]  b;
    logic [DEF_OPW-1:0] op;
`ifdef ALU_CHAIN_FWD_EN
    logic               chain;
`endif
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
// Module      : alu_cmd_fifo
// Description : DEPTH-entry synchronous FIFO of cmd_t with a
//               combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  cmd_t                     wdata_i,
  input  logic                     pop_i,
  output cmd_t                     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push,  do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens on the same edge.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Queues ALU commands, issues one per cycle to an external ALU
//               and captures its result behind a valid/ready handshake.
//               Define ALU_CHAIN_FWD_EN to add result chaining into operand A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int OPW   = DEF_OPW,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_a,
  input  logic [DW-1:0]          in_b,
  input  logic [OPW-1:0]         in_op,
`ifdef ALU_CHAIN_FWD_EN
  input  logic                   in_chain,
`endif
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  output logic [OPW-1:0]         alu_op,
  input  logic [DW-1:0]          alu_r,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DW-1:0]          res_data,
  output logic [OPW-1:0]         res_op,
  output logic [$clog2(DEPTH):0] cmd_count
);

  cmd_t           wr_cmd, head;
  logic           fifo_full, fifo_empty, issue;
  logic           res_valid_q, res_valid_d;
  logic [DW-1:0]  res_data_q,  res_data_d;
  logic [OPW-1:0] res_op_q,    res_op_d;

  always_comb begin
    wr_cmd    = '0;
    wr_cmd.a  = in_a;
    wr_cmd.b  = in_b;
    wr_cmd.op = in_op;
`ifdef ALU_CHAIN_FWD_EN
    wr_cmd.chain = in_chain;
`endif
  end

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i (wr_cmd),
    .pop_i   (issue),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (cmd_count)
  );

  assign in_ready = ~fifo_full;
  assign issue    = ~fifo_empty & (~res_valid_q | res_ready);

`ifdef ALU_CHAIN_FWD_EN
  logic [DW-1:0] last_r_q, last_r_d;

  assign last_r_d = issue ? alu_r : last_r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) last_r_q <= '0;
    else        last_r_q <= last_r_d;
  end

  assign alu_a = fifo_empty ? '0 : (head.chain ? last_r_q : head.a);
`else
  assign alu_a = fifo_empty ? '0 : head.a;
`endif
  assign alu_b  = fifo_empty ? '0 : head.b;
  assign alu_op = fifo_empty ? '0 : head.op;

  // Data and opcode only change on issue so a stalled result stays stable.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_r;
      res_op_d    = head.op;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Directed bench for alu_cmd_sequencer with an adder ALU stub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
`ifdef ALU_CHAIN_FWD_EN
  logic       in_chain;
`endif
  logic [7:0] alu_a, alu_b, alu_r;
  logic [2:0] alu_op;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic [2:0] cmd_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign alu_r = alu_a + alu_b;

  alu_cmd_sequencer #(.DW(8), .OPW(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
`ifdef ALU_CHAIN_FWD_EN
    .in_chain  (in_chain),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .cmd_count (cmd_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    n_tests++; if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", res_data); end
    n_tests++; if (res_op !== 3'd0) begin n_fail++; $display("FAIL reset_op got=%0d exp=0", res_op); end
    n_tests++; if (cmd_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cmd_count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_tests++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL reset_alu_a got=%h exp=00", alu_a); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h6A; in_b = 8'h3B; in_op = 3'd0;
    tick();
    in_valid = 1'b0;
    n_tests++; if (cmd_count !== 3'd1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL single_queued count=%0d valid=%b exp 1/0", cmd_count, res_valid); end
    n_tests++; if (alu_a !== 8'h6A || alu_b !== 8'h3B) begin n_fail++; $display("FAIL single_head a=%h b=%h exp 6a/3b", alu_a, alu_b); end
    tick();
    n_tests++; if (res_valid !== 1'b1 || res_data !== 8'hA5 || res_op !== 3'd0) begin n_fail++; $display("FAIL single_result valid=%b data=%h op=%0d exp 1/a5/0", res_valid, res_data, res_op); end
    n_tests++; if (cmd_count !== 3'd0) begin n_fail++; $display("FAIL single_count got=%0d exp=0", cmd_count); end
    tick();
    n_tests++; if (res_valid !== 1'b0 || res_data !== 8'hA5) begin n_fail++; $display("FAIL single_one_cycle valid=%b data=%h exp 0/a5", res_valid, res_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    res_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_a = 8'(k * 16 + 1); in_b = 8'(k * 3); in_op = 3'(k);
      tick();
      n_tests++; if (cmd_count > 3'd1) begin n_fail++; $display("FAIL b2b_count k=%0d got=%0d exp<=1", k, cmd_count); end
      if (k >= 1) begin
        exp_d = 8'((k - 1) * 16 + 1 + (k - 1) * 3);
        n_tests++;
        if (res_valid !== 1'b1 || res_op !== 3'(k - 1) || res_data !== exp_d) begin
          n_fail++; $display("FAIL b2b_result k=%0d valid=%b op=%0d data=%h exp 1/%0d/%h", k, res_valid, res_op, res_data, k - 1, exp_d);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle valid=%b exp=0", res_valid); end
  endtask

  task automatic test_backpressure();
    int exp_cnt [5] = '{3, 3, 2, 1, 0};
    res_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_a = 8'h20 + 8'(j); in_b = 8'h40; in_op = 3'(j);
      tick();
      if (j >= 1) begin
        n_tests++; if (res_valid !== 1'b1 || res_data !== 8'h60 || res_op !== 3'd0) begin n_fail++; $display("FAIL bp_hold j=%0d valid=%b data=%h op=%0d exp 1/60/0", j, res_valid, res_data, res_op); end
      end
    end
    n_tests++; if (cmd_count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full count=%0d in_ready=%b exp 4/0", cmd_count, in_ready); end
    in_a = 8'h25; in_op = 3'd5;
    tick();
    n_tests++; if (cmd_count !== 3'd4 || res_data !== 8'h60) begin n_fail++; $display("FAIL bp_blocked count=%0d data=%h exp 4/60", cmd_count, res_data); end
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || res_data !== 8'h61 + 8'(k) || res_op !== 3'(k + 1) || cmd_count !== 3'(exp_cnt[k])) begin
        n_fail++; $display("FAIL bp_drain k=%0d valid=%b data=%h op=%0d count=%0d exp 1/%h/%0d/%0d", k, res_valid, res_data, res_op, cmd_count, 8'h61 + 8'(k), k + 1, exp_cnt[k]);
      end
      if (k == 0) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=1", in_ready); end
      end
      if (k == 1) in_valid = 1'b0;
    end
    tick();
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle valid=%b exp=0", res_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    for (int r = 0; r < 3; r++) begin
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; in_a = 8'(r * 48 + i * 7); in_b = 8'(8'h85 + i); in_op = 3'(r + i);
        tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        exp_d = 8'(r * 48 + i * 7 + 8'h85 + i);
        n_tests++;
        if (res_valid !== 1'b1 || res_data !== exp_d || res_op !== 3'(r + i) || cmd_count !== 3'(3 - i)) begin
          n_fail++; $display("FAIL wrap r=%0d i=%0d valid=%b data=%h op=%0d count=%0d exp 1/%h/%0d/%0d", r, i, res_valid, res_data, res_op, cmd_count, exp_d, r + i, 3 - i);
        end
        res_ready = 1'b1;
      end
      tick();
      n_tests++; if (res_valid !== 1'b0 || cmd_count !== 3'd0) begin n_fail++; $display("FAIL wrap_idle r=%0d valid=%b count=%0d exp 0/0", r, res_valid, cmd_count); end
    end
  endtask

  task automatic test_reset_midstream();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 8'h11 * 8'(i + 1); in_b = 8'h01; in_op = 3'(i + 2);
      tick();
    end
    in_valid = 1'b0;
    n_tests++; if (cmd_count !== 3'd3 || res_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup count=%0d valid=%b exp 3/1", cmd_count, res_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++; if (cmd_count !== 3'd0 || res_valid !== 1'b0 || res_data !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_flush count=%0d valid=%b data=%h in_ready=%b exp 0/0/00/1", cmd_count, res_valid, res_data, in_ready);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (res_valid !== 1'b0 || cmd_count !== 3'd0) begin n_fail++; $display("FAIL mid_quiet k=%0d valid=%b count=%0d exp 0/0", k, res_valid, cmd_count); end
    end
  endtask

`ifdef ALU_CHAIN_FWD_EN
  task automatic test_chain();
    res_ready = 1'b1;
    in_valid = 1'b1; in_chain = 1'b0; in_a = 8'h10; in_b = 8'h01; in_op = 3'd1;
    tick();
    in_chain = 1'b1; in_a = 8'hEE; in_b = 8'h02; in_op = 3'd2;
    tick();
    in_valid = 1'b0; in_chain = 1'b0;
    n_tests++; if (res_valid !== 1'b1 || res_data !== 8'h11) begin n_fail++; $display("FAIL chain_first valid=%b data=%h exp 1/11", res_valid, res_data); end
    tick();
    n_tests++; if (res_valid !== 1'b1 || res_data !== 8'h13 || res_op !== 3'd2) begin n_fail++; $display("FAIL chain_second valid=%b data=%h op=%0d exp 1/13/2", res_valid, res_data, res_op); end
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; res_ready = 1'b0;
`ifdef ALU_CHAIN_FWD_EN
    in_chain = 1'b0;
`endif
    tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_midstream();
`ifdef ALU_CHAIN_FWD_EN
    test_chain();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
